wb_tia_audio: RTL and testbench

WB_TIA_AUDIO -- requirements
Module: wb_tia_audio

---
 rtl/wb_tia_audio_pkg.sv | 93 +++++++++
 rtl/wb_tia_audio_channel.sv | 46 ++++
 rtl/wb_tia_audio.sv | 149 ++++++++++++++
 tb/tb_wb_tia_audio.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_tia_audio_pkg.sv
// Shared constants, generator state and helper functions for the TIA-style audio block.
// Register map, AUDC waveform codes and LFSR tap positions all live here.
package wb_tia_audio_pkg;

  localparam logic [1:0] REG_AUDC = 2'd0;
  localparam logic [1:0] REG_AUDF = 2'd1;
  localparam logic [1:0] REG_AUDV = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  // Canonical AUDC codes; the remaining codes alias onto these sources.
  localparam logic [3:0] AUDC_ONE   = 4'h0;
  localparam logic [3:0] AUDC_POLY4 = 4'h1;
  localparam logic [3:0] AUDC_DIV31 = 4'h2;
  localparam logic [3:0] AUDC_POLY5 = 4'h3;
  localparam logic [3:0] AUDC_TONE  = 4'h4;
  localparam logic [3:0] AUDC_POLY9 = 4'h8;
  localparam logic [3:0] AUDC_DIV3  = 4'hC;

  // Middle exponent of each trinomial x^N + x^TAP + 1.
  localparam int POLY4_TAP  = 3;
  localparam int POLY5_TAP  = 3;
  localparam int POLY9_TAP  = 5;
  localparam int DIV31_HIGH = 13;

  typedef enum logic [2:0] {
    SRC_ONE,
    SRC_POLY4,
    SRC_POLY5,
    SRC_TOGGLE,
    SRC_POLY9,
    SRC_DIV3,
    SRC_DIV31
  } ch_src_e;

  typedef struct packed {
    logic [3:0] poly4;
    logic [4:0] poly5;
    logic [8:0] poly9;
    logic       tog;
    logic [1:0] mod3;
    logic       div3_flop;
    logic [4:0] mod31;
  } gen_state_t;

  // An all-zero LFSR would lock up, so they come out of reset as all-ones.
  localparam gen_state_t GEN_RESET = '{
    poly4: 4'hF, poly5: 5'h1F, poly9: 9'h1FF,
    tog: 1'b0, mod3: 2'd0, div3_flop: 1'b0, mod31: 5'd0
  };

  function automatic ch_src_e audc_src(input logic [3:0] audc);
    ch_src_e src;
    case (audc)
      AUDC_ONE, 4'hB:                 src = SRC_ONE;
      AUDC_POLY4:                     src = SRC_POLY4;
      AUDC_POLY5, 4'h7, 4'h9, 4'hF:   src = SRC_POLY5;
      AUDC_TONE, 4'h5:                src = SRC_TOGGLE;
      AUDC_POLY9:                     src = SRC_POLY9;
      AUDC_DIV3, 4'hD:                src = SRC_DIV3;
      AUDC_DIV31, 4'h6, 4'hA, 4'hE:   src = SRC_DIV31;
      default:                        src = SRC_ONE;
    endcase
    return src;
  endfunction

  function automatic gen_state_t gen_step(input gen_state_t s);
    gen_state_t n;
    n           = s;
    n.poly4     = {s.poly4[0] ^ s.poly4[POLY4_TAP], s.poly4[3:1]};
    n.poly5     = {s.poly5[0] ^ s.poly5[POLY5_TAP], s.poly5[4:1]};
    n.poly9     = {s.poly9[0] ^ s.poly9[POLY9_TAP], s.poly9[8:1]};
    n.tog       = ~s.tog;
    n.mod3      = (s.mod3 == 2'd2) ? 2'd0 : s.mod3 + 2'd1;
    n.div3_flop = s.div3_flop ^ (s.mod3 == 2'd2);
    n.mod31     = (s.mod31 == 5'd30) ? 5'd0 : s.mod31 + 5'd1;
    return n;
  endfunction

  function automatic logic gen_bit(input logic [3:0] audc, input gen_state_t s);
    logic b;
    case (audc_src(audc))
      SRC_POLY4:  b = s.poly4[0];
      SRC_POLY5:  b = s.poly5[0];
      SRC_TOGGLE: b = s.tog;
      SRC_POLY9:  b = s.poly9[0];
      SRC_DIV3:   b = s.div3_flop;
      SRC_DIV31:  b = (s.mod31 < 5'(DIV31_HIGH));
      default:    b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wb_tia_audio_channel.sv
// One audio channel: 5-bit frequency divider feeding a polynomial/counter waveform generator.
// o_ch_bit_next is the value the waveform bit takes on the current tick, for the mixer.
module tia_audio_channel
  import wb_tia_audio_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_tick,
  input  logic [3:0] i_audc,
  input  logic [4:0] i_audf,
  output logic       o_ch_bit,
  output logic       o_ch_bit_next
);

  logic [4:0] r_div;
  gen_state_t r_gen;
  logic       r_ch_bit;

  logic       w_step;
  gen_state_t w_gen_next;
  logic       w_bit_next;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_step     = i_tick && (r_div >= i_audf);
    w_gen_next = w_step ? gen_step(r_gen) : r_gen;
    w_bit_next = i_tick ? gen_bit(i_audc, w_gen_next) : r_ch_bit;
  end

  // NOTE: state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div    <= 5'd0;
      r_gen    <= GEN_RESET;
      r_ch_bit <= 1'b0;
    end else if (i_tick) begin
      r_div    <= w_step ? 5'd0 : r_div + 5'd1;
      r_gen    <= w_gen_next;
      r_ch_bit <= w_bit_next;
    end
  end

  assign o_ch_bit      = r_ch_bit;
  assign o_ch_bit_next = w_bit_next;

endmodule

// File: rtl/wb_tia_audio.sv
// TIA-style multi-channel audio generator with a Wishbone-like register port,
// a registered sample mixer and a 1-bit PWM output.
module wb_tia_audio
  import wb_tia_audio_pkg::*;
#(
  parameter  int NUM_CH        = 2,
  parameter  int WB_DATA_WIDTH = 8,
  parameter  int WB_ADDR_WIDTH = 7,
  parameter  int AUD_DIV       = 512,
  localparam int MIX_W         = 4 + $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic                     ack_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  output logic [MIX_W-1:0]         sample_o,
  output logic                     sample_valid_o,
  output logic                     pwm_o,
  output logic [NUM_CH-1:0]        ch_bit_o
);

  localparam int CH_W   = WB_ADDR_WIDTH - 2;
  localparam int TICK_W = (AUD_DIV > 1) ? $clog2(AUD_DIV) : 1;

  logic [3:0]               r_audc [NUM_CH];
  logic [4:0]               r_audf [NUM_CH];
  logic [3:0]               r_audv [NUM_CH];
  logic                     r_ack;
  logic [WB_DATA_WIDTH-1:0] r_dat;
  logic [TICK_W-1:0]        r_tick_cnt;
  logic                     r_valid;
  logic [MIX_W-1:0]         r_sample;
  logic [MIX_W-1:0]         r_pwm_cnt;
  logic                     r_pwm;

  logic [CH_W-1:0]          w_ch;
  logic [1:0]               w_off;
  logic                     w_ch_ok;
  logic                     w_wr;
  logic                     w_tick;
  logic [WB_DATA_WIDTH-1:0] w_rd;
  logic [MIX_W-1:0]         w_mix;
  logic [NUM_CH-1:0]        w_ch_bit;
  logic [NUM_CH-1:0]        w_bit_next;
  logic                     w_unused;

  // Only the low five data bits ever reach a register.
  assign w_unused = ^dat_i[WB_DATA_WIDTH-1:5];

  assign w_ch    = adr_i[WB_ADDR_WIDTH-1:2];
  assign w_off   = adr_i[1:0];
  assign w_ch_ok = int'(w_ch) < NUM_CH;
  assign w_wr    = stb_i && we_i && w_ch_ok && (w_off != REG_STAT);
  assign w_tick  = (r_tick_cnt == TICK_W'(AUD_DIV - 1));

  // NOTE: the register file is a handful of flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_audc[c] <= 4'd0;
        r_audf[c] <= 5'd0;
        r_audv[c] <= 4'd0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr && int'(w_ch) == c) begin
          case (w_off)
            REG_AUDC: r_audc[c] <= dat_i[3:0];
            REG_AUDF: r_audf[c] <= dat_i[4:0];
            REG_AUDV: r_audv[c] <= dat_i[3:0];
            default:  ;
          endcase
        end
      end
    end
  end

  always_comb begin
    w_rd = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch_ok && int'(w_ch) == c) begin
        case (w_off)
          REG_AUDC: w_rd = WB_DATA_WIDTH'(r_audc[c]);
          REG_AUDF: w_rd = WB_DATA_WIDTH'(r_audf[c]);
          REG_AUDV: w_rd = WB_DATA_WIDTH'(r_audv[c]);
          default:  w_rd = WB_DATA_WIDTH'(w_ch_bit[c]);
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= stb_i;
      if (stb_i) r_dat <= w_rd;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tia_audio_channel u_ch (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .i_tick        (w_tick),
      .i_audc        (r_audc[g]),
      .i_audf        (r_audf[g]),
      .o_ch_bit      (w_ch_bit[g]),
      .o_ch_bit_next (w_bit_next[g])
    );
  end

  // Mix from the bits the channels take on this tick so sample_o and ch_bit_o stay aligned.
  always_comb begin
    w_mix = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_bit_next[c]) w_mix = w_mix + MIX_W'(r_audv[c]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tick_cnt <= '0;
      r_valid    <= 1'b0;
      r_sample   <= '0;
      r_pwm_cnt  <= '0;
      r_pwm      <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_valid    <= w_tick;
      if (w_tick) r_sample <= w_mix;
      r_pwm_cnt  <= r_pwm_cnt + 1'b1;
      r_pwm      <= (r_pwm_cnt < r_sample);
    end
  end

  assign ack_o          = r_ack;
  assign dat_o          = r_dat;
  assign sample_o       = r_sample;
  assign sample_valid_o = r_valid;
  assign pwm_o          = r_pwm;
  assign ch_bit_o       = w_ch_bit;

endmodule

// File: tb/tb_wb_tia_audio.sv
// Directed bench for wb_tia_audio with NUM_CH=2, AUD_DIV=4 (tick every 4 clocks).
module tb_wb_tia_audio;

  localparam int NUM_CH  = 2;
  localparam int AUD_DIV = 4;
  localparam int MIX_W   = 5;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             stb_i;
  logic             we_i;
  logic [6:0]       adr_i;
  logic [7:0]       dat_i;
  logic             ack_o;
  logic [7:0]       dat_o;
  logic [MIX_W-1:0] sample_o;
  logic             sample_valid_o;
  logic             pwm_o;
  logic [NUM_CH-1:0] ch_bit_o;

  int n_checks = 0;
  int n_errors = 0;

  logic bits [1022];

  wb_tia_audio #(
    .NUM_CH        (NUM_CH),
    .WB_DATA_WIDTH (8),
    .WB_ADDR_WIDTH (7),
    .AUD_DIV       (AUD_DIV)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .stb_i          (stb_i),
    .we_i           (we_i),
    .adr_i          (adr_i),
    .dat_i          (dat_i),
    .ack_o          (ack_o),
    .dat_o          (dat_o),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .pwm_o          (pwm_o),
    .ch_bit_o       (ch_bit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic bus_write(input int ch, input int off, input int data);
    @(negedge clk_i);
    stb_i = 1'b1;
    we_i  = 1'b1;
    adr_i = 7'(ch * 4 + off);
    dat_i = 8'(data);
    @(negedge clk_i);
    check("write_ack", 32'(ack_o), 1);
    stb_i = 1'b0;
    we_i  = 1'b0;
  endtask

  task automatic bus_read(input int ch, input int off, output logic [7:0] data);
    @(negedge clk_i);
    stb_i = 1'b1;
    we_i  = 1'b0;
    adr_i = 7'(ch * 4 + off);
    @(negedge clk_i);
    data  = dat_o;
    stb_i = 1'b0;
  endtask

  // Always advances at least one clock, so a pulse already being observed is not re-counted.
  task automatic wait_valid(output logic [MIX_W-1:0] smp, output logic [NUM_CH-1:0] cb);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_i);
      if (sample_valid_o) found = 1'b1;
    end
    check("tick_seen", 32'(found), 1);
    smp = sample_o;
    cb  = ch_bit_o;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]       rd;
    logic [MIX_W-1:0] s [6];
    logic [MIX_W-1:0] smp;
    logic [NUM_CH-1:0] cb;
    int ones, miss, hi, n;
    logic found;

    rst_ni = 1'b0;
    stb_i  = 1'b0;
    we_i   = 1'b0;
    adr_i  = '0;
    dat_i  = '0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_sample", 32'(sample_o), 0);
    check("rst_valid", 32'(sample_valid_o), 0);
    check("rst_chbit", 32'(ch_bit_o), 0);
    check("rst_ack", 32'(ack_o), 0);
    rst_ni = 1'b1;
    bus_read(0, 0, rd);
    check("rst_audc", 32'(rd), 0);

    // Square tone: toggle source stepping every tick
    bus_write(0, 2, 15);
    bus_write(0, 0, 4);
    bus_write(0, 1, 0);
    wait_valid(smp, cb);
    for (int i = 0; i < 5; i++) wait_valid(s[i], cb);
    check("tone_level", 32'(s[0] == 0 || s[0] == 15), 1);
    for (int i = 0; i < 4; i++) check("tone_alt", 32'(s[i+1]), 32'(15 - s[i]));

    // AUDF=3 written in the tick cycle: that tick still steps with AUDF=0, then every 4th tick
    wait_valid(s[0], cb);
    repeat (3) @(negedge clk_i);
    stb_i = 1'b1;
    we_i  = 1'b1;
    adr_i = 7'(0 * 4 + 1);
    dat_i = 8'd3;
    @(negedge clk_i);
    check("edge_valid_aligned", 32'(sample_valid_o), 1);
    check("edge_ack", 32'(ack_o), 1);
    s[1]  = sample_o;
    stb_i = 1'b0;
    we_i  = 1'b0;
    check("edge_pre_write_step", 32'(s[1]), 32'(15 - s[0]));
    for (int i = 2; i < 6; i++) wait_valid(s[i], cb);
    check("div4_hold1", 32'(s[2]), 32'(s[1]));
    check("div4_hold2", 32'(s[3]), 32'(s[1]));
    check("div4_hold3", 32'(s[4]), 32'(s[1]));
    check("div4_toggle", 32'(s[5]), 32'(15 - s[1]));
    bus_read(0, 1, rd);
    check("audf_readback", 32'(rd), 3);

    // poly4: period 15, 8 ones per period
    bus_write(0, 1, 0);
    bus_write(0, 0, 1);
    repeat (2) wait_valid(smp, cb);
    for (int i = 0; i < 30; i++) begin
      wait_valid(smp, cb);
      bits[i] = cb[0];
    end
    ones = 0;
    miss = 0;
    for (int i = 0; i < 15; i++) begin
      ones += int'(bits[i]);
      if (bits[i] !== bits[i+15]) miss++;
    end
    check("poly4_period", 32'(miss), 0);
    check("poly4_ones", 32'(ones), 8);

    // poly9: period 511, 256 ones per period
    bus_write(0, 0, 8);
    repeat (2) wait_valid(smp, cb);
    for (int i = 0; i < 1022; i++) begin
      wait_valid(smp, cb);
      bits[i] = cb[0];
    end
    ones = 0;
    miss = 0;
    for (int i = 0; i < 511; i++) begin
      ones += int'(bits[i]);
      if (bits[i] !== bits[i+511]) miss++;
    end
    check("poly9_period", 32'(miss), 0);
    check("poly9_ones", 32'(ones), 256);

    // Mixing: two constant-one channels at full volume
    bus_write(0, 0, 0);
    bus_write(1, 0, 0);
    bus_write(1, 2, 15);
    repeat (2) wait_valid(smp, cb);
    check("mix_sample", 32'(smp), 30);
    check("mix_chbits", 32'(cb), 3);
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      hi += int'(pwm_o);
    end
    check("mix_pwm_duty", 32'(hi), 30);

    // Out-of-range channel and read-only status
    bus_write(NUM_CH, 0, 5);
    bus_write(NUM_CH, 2, 9);
    bus_read(NUM_CH, 0, rd);
    check("oor_read_audc", 32'(rd), 0);
    bus_read(NUM_CH, 2, rd);
    check("oor_read_audv", 32'(rd), 0);
    bus_read(0, 0, rd);
    check("oor_ch0_audc", 32'(rd), 0);
    bus_read(0, 2, rd);
    check("ch0_audv", 32'(rd), 15);
    bus_write(0, 3, 0);
    bus_read(0, 3, rd);
    check("status_ro", 32'(rd), 1);
    wait_valid(smp, cb);
    check("oor_sample_kept", 32'(smp), 30);

    // Reset mid-tone
    bus_write(1, 2, 0);
    bus_write(0, 0, 4);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      wait_valid(smp, cb);
      if (smp == 15) found = 1'b1;
    end
    check("tone_before_reset", 32'(found), 1);
    bus_read(0, 2, rd);
    check("dat_before_reset", 32'(dat_o), 15);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_sample", 32'(sample_o), 0);
    check("async_rst_valid", 32'(sample_valid_o), 0);
    check("async_rst_chbit", 32'(ch_bit_o), 0);
    check("async_rst_dat", 32'(dat_o), 0);
    check("async_rst_pwm", 32'(pwm_o), 0);
    check("async_rst_ack", 32'(ack_o), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk_i);
      if (sample_valid_o) begin
        found = 1'b1;
        n = i;
      end
    end
    check("first_tick_latency", 32'(n), 4);
    check("first_tick_sample", 32'(sample_o), 0);
    bus_read(0, 0, rd);
    check("post_rst_audc", 32'(rd), 0);
    bus_read(0, 2, rd);
    check("post_rst_audv", 32'(rd), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
